spi_bridge_seq: RTL and testbench

Parameterised register-file-to-SPI sequencer replacing the single-byte bridge logic between the I2C-visible register file (dram port 2) and `spi_master`. It polls a control byte written by the I2C host, performs a burst of 1..MAX_LEN SPI byte transactions with auto-incrementing SPI register address, writes each received byte back to the register file, and reports completion and timeout status in the control byte. It is the only master of dram port 2 and of the `spi_master` register bus.

---
 rtl/spi_bridge_seq.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_spi_bridge_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bridge_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_bridge_seq : polls a register-file control byte and runs a burst of   |
// | SPI byte transactions through spi_master, writing RX bytes back.          |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module spi_bridge_seq #(
   parameter int AW       = 4,
   parameter int DW       = 8,
   parameter int MAX_LEN  = 4,
   parameter int CTRL_ADR = 'h2,
   parameter int ADDR_ADR = 'h0,
   parameter int TX_BASE  = 'h4,
   parameter int RX_BASE  = 'h8,
   parameter int POLL_GAP = 8,
   parameter int TIMEOUT  = 1024
) (
   input  logic          i_ck,
   input  logic          i_rstn,
   output logic [AW-1:0] o_ram_addr,
   output logic [DW-1:0] o_ram_wdata,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_ram_rw,
   output logic          o_ram_csn,
   output logic [3:0]    o_spi_adr,
   output logic [DW-1:0] o_spi_din,
   input  logic [DW-1:0] i_spi_dout,
   output logic          o_spi_wr,
   output logic          o_spi_rd,
   output logic          o_busy,
   output logic          o_err
);

   localparam int c_gw = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam int c_tw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_gw-1:0] c_gap_last  = c_gw'(POLL_GAP - 1);
   localparam logic [c_tw-1:0] c_poll_last = c_tw'(TIMEOUT - 1);
   localparam logic [3:0]      c_max_len   = 4'(MAX_LEN);
   localparam logic [3:0]      c_spi_ctrl  = 4'd0;
   localparam logic [3:0]      c_spi_tx    = 4'd1;
   localparam logic [3:0]      c_spi_addr  = 4'd2;
   localparam logic [3:0]      c_spi_rx    = 4'd3;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_RD_CTRL  = 4'd1,
      S_RD_ADDR  = 4'd2,
      S_RD_TX    = 4'd3,
      S_SPI_WADR = 4'd4,
      S_SPI_WTX  = 4'd5,
      S_SPI_GO   = 4'd6,
      S_SPI_POLL = 4'd7,
      S_SPI_RRX  = 4'd8,
      S_WR_RX    = 4'd9,
      S_WR_CTRL  = 4'd10
   } state_t;

   state_t          r_state, w_state;
   logic            r_ph, w_ph;           // 0 = strobe cycle, 1 = capture cycle
   logic [c_gw-1:0] r_gap, w_gap;
   logic [c_tw-1:0] r_poll, w_poll;
   logic [2:0]      r_idx, w_idx;
   logic [2:0]      r_len_m1, w_len_m1;
   logic [4:0]      r_ctrl, w_ctrl;       // control bits [5:1] echoed on write-back
   logic [DW-1:0]   r_base, w_base;
   logic [DW-1:0]   r_tx, w_tx;
   logic [DW-1:0]   r_rx, w_rx;
   logic            r_busy, w_busy;
   logic            r_err, w_err;

   logic [AW-1:0]   w_tx_addr;
   logic [AW-1:0]   w_rx_addr;
   logic            w_len_ok;

   assign w_tx_addr = AW'(TX_BASE) + AW'(r_idx);
   assign w_rx_addr = AW'(RX_BASE) + AW'(r_idx);
   assign w_len_ok  = ({1'b0, i_ram_rdata[3:1]} + 4'd1) <= c_max_len;

   always_ff @(posedge i_ck or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state  <= S_IDLE;
         r_ph     <= 1'b0;
         r_gap    <= '0;
         r_poll   <= '0;
         r_idx    <= '0;
         r_len_m1 <= '0;
         r_ctrl   <= '0;
         r_base   <= '0;
         r_tx     <= '0;
         r_rx     <= '0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_ph     <= w_ph;
         r_gap    <= w_gap;
         r_poll   <= w_poll;
         r_idx    <= w_idx;
         r_len_m1 <= w_len_m1;
         r_ctrl   <= w_ctrl;
         r_base   <= w_base;
         r_tx     <= w_tx;
         r_rx     <= w_rx;
         r_busy   <= w_busy;
         r_err    <= w_err;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_ph        = r_ph;
      w_gap       = r_gap;
      w_poll      = r_poll;
      w_idx       = r_idx;
      w_len_m1    = r_len_m1;
      w_ctrl      = r_ctrl;
      w_base      = r_base;
      w_tx        = r_tx;
      w_rx        = r_rx;
      w_busy      = r_busy;
      w_err       = r_err;
      o_ram_addr  = '0;
      o_ram_wdata = '0;
      o_ram_rw    = 1'b1;
      o_ram_csn   = 1'b1;
      o_spi_adr   = '0;
      o_spi_din   = '0;
      o_spi_wr    = 1'b0;
      o_spi_rd    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (r_gap == c_gap_last) begin
               w_gap   = '0;
               w_ph    = 1'b0;
               w_state = S_RD_CTRL;
            end else begin
               w_gap = r_gap + 1'b1;
            end
         end

         S_RD_CTRL: begin
            o_ram_addr = AW'(CTRL_ADR);
            if (!r_ph) begin
               o_ram_csn = 1'b0;
               w_ph      = 1'b1;
            end else begin
               w_ph = 1'b0;
               if (!i_ram_rdata[0]) begin
                  w_state = S_IDLE;
               end else begin
                  w_ctrl   = i_ram_rdata[5:1];
                  w_len_m1 = i_ram_rdata[3:1];
                  if (w_len_ok) begin
                     w_err   = 1'b0;
                     w_busy  = 1'b1;
                     w_state = S_RD_ADDR;
                  end else begin
                     // Illegal length: report it without touching the SPI bus.
                     w_err   = 1'b1;
                     w_state = S_WR_CTRL;
                  end
               end
            end
         end

         S_RD_ADDR: begin
            o_ram_addr = AW'(ADDR_ADR);
            if (!r_ph) begin
               o_ram_csn = 1'b0;
               w_ph      = 1'b1;
            end else begin
               w_ph    = 1'b0;
               w_base  = i_ram_rdata;
               w_idx   = '0;
               w_state = S_RD_TX;
            end
         end

         S_RD_TX: begin
            o_ram_addr = w_tx_addr;
            if (!r_ph) begin
               o_ram_csn = 1'b0;
               w_ph      = 1'b1;
            end else begin
               w_ph    = 1'b0;
               w_tx    = i_ram_rdata;
               w_state = S_SPI_WADR;
            end
         end

         S_SPI_WADR: begin
            o_spi_wr  = 1'b1;
            o_spi_adr = c_spi_addr;
            o_spi_din = r_base + DW'(r_idx);
            w_state   = S_SPI_WTX;
         end

         S_SPI_WTX: begin
            o_spi_wr  = 1'b1;
            o_spi_adr = c_spi_tx;
            o_spi_din = r_tx;
            w_state   = S_SPI_GO;
         end

         S_SPI_GO: begin
            o_spi_wr  = 1'b1;
            o_spi_adr = c_spi_ctrl;
            o_spi_din = DW'(1);
            w_poll    = '0;
            w_ph      = 1'b0;
            w_state   = S_SPI_POLL;
         end

         S_SPI_POLL: begin
            o_spi_adr = c_spi_ctrl;
            if (!r_ph) begin
               o_spi_rd = 1'b1;
               w_ph     = 1'b1;
            end else begin
               w_ph = 1'b0;
               if (!i_spi_dout[0]) begin
                  w_state = S_SPI_RRX;
               end else if (r_poll == c_poll_last) begin
                  w_err   = 1'b1;
                  w_state = S_WR_CTRL;
               end else begin
                  w_poll = r_poll + 1'b1;
               end
            end
         end

         S_SPI_RRX: begin
            o_spi_adr = c_spi_rx;
            if (!r_ph) begin
               o_spi_rd = 1'b1;
               w_ph     = 1'b1;
            end else begin
               w_ph    = 1'b0;
               w_rx    = i_spi_dout;
               w_state = S_WR_RX;
            end
         end

         S_WR_RX: begin
            o_ram_csn   = 1'b0;
            o_ram_rw    = 1'b0;
            o_ram_addr  = w_rx_addr;
            o_ram_wdata = r_rx;
            if (r_idx == r_len_m1) begin
               w_state = S_WR_CTRL;
            end else begin
               w_idx   = r_idx + 1'b1;
               w_state = S_RD_TX;
            end
         end

         S_WR_CTRL: begin
            o_ram_csn   = 1'b0;
            o_ram_rw    = 1'b0;
            o_ram_addr  = AW'(CTRL_ADR);
            o_ram_wdata = DW'({1'b1, r_err, r_ctrl, 1'b0});
            w_busy      = 1'b0;
            w_gap       = '0;
            w_state     = S_IDLE;
         end

         default: begin
            w_state = S_IDLE;
            w_ph    = 1'b0;
            w_gap   = '0;
         end
      endcase
   end

   assign o_busy = r_busy;
   assign o_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_bridge_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_bridge_seq : directed bench with register-file and spi_master      |
// | models for spi_bridge_seq.                                                |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_spi_bridge_seq;

   logic       r_ck   = 1'b0;
   logic       r_rstn = 1'b0;
   logic [3:0] w_ram_addr;
   logic [7:0] w_ram_wdata;
   logic [7:0] r_ram_rdata = 8'h00;
   logic       w_ram_rw;
   logic       w_ram_csn;
   logic [3:0] w_spi_adr;
   logic [7:0] w_spi_din;
   logic [7:0] r_spi_dout = 8'h00;
   logic       w_spi_wr;
   logic       w_spi_rd;
   logic       w_busy;
   logic       w_err;

   always #5 r_ck = ~r_ck;

   spi_bridge_seq u_dut (
      .i_ck        (r_ck),
      .i_rstn      (r_rstn),
      .o_ram_addr  (w_ram_addr),
      .o_ram_wdata (w_ram_wdata),
      .i_ram_rdata (r_ram_rdata),
      .o_ram_rw    (w_ram_rw),
      .o_ram_csn   (w_ram_csn),
      .o_spi_adr   (w_spi_adr),
      .o_spi_din   (w_spi_din),
      .i_spi_dout  (r_spi_dout),
      .o_spi_wr    (w_spi_wr),
      .o_spi_rd    (w_spi_rd),
      .o_busy      (w_busy),
      .o_err       (w_err)
   );

   logic [7:0]  mem [16];
   logic        r_hwe   = 1'b0;
   logic [3:0]  r_haddr = 4'h0;
   logic [7:0]  r_hdata = 8'h00;
   logic [7:0]  r_last_tx = 8'h00;
   logic [11:0] wlog [$];
   int cyc = 0, n_spiwr = 0, n_spird = 0, n_polls = 0, n_overlap = 0;
   int last_ctrl_rd = 0, ctrl_wr_cyc = 0, prev_rd = -1, rd_gap = 0;
   int poll_need = 1, poll_left = 0;
   int n_cmp = 0, n_bad = 0;

   always @(posedge r_ck) cyc <= cyc + 1;

   // Register file, spi_master and bus monitor, all evaluated mid-cycle.
   always @(negedge r_ck) begin
      if (r_hwe) mem[r_haddr] <= r_hdata;
      if (!w_ram_csn && !w_ram_rw) begin
         mem[w_ram_addr] <= w_ram_wdata;
         if (w_ram_addr == 4'h2) ctrl_wr_cyc <= cyc;
      end
      if (!w_ram_csn && w_ram_rw) begin
         r_ram_rdata <= mem[w_ram_addr];
         if (w_ram_addr == 4'h2) begin
            last_ctrl_rd <= cyc;
            if (prev_rd >= 0) rd_gap <= cyc - prev_rd;
            prev_rd <= cyc;
         end
      end
      if (w_spi_wr) begin
         n_spiwr <= n_spiwr + 1;
         wlog.push_back({w_spi_adr, w_spi_din});
         if (w_spi_adr == 4'd1) r_last_tx <= w_spi_din;
         if (w_spi_adr == 4'd0 && w_spi_din[0]) poll_left <= poll_need - 1;
      end
      if (w_spi_rd) begin
         n_spird <= n_spird + 1;
         if (w_spi_adr == 4'd0) begin
            n_polls    <= n_polls + 1;
            r_spi_dout <= {7'b0, (poll_left != 0)};
            if (poll_left != 0) poll_left <= poll_left - 1;
         end else if (w_spi_adr == 4'd3) begin
            r_spi_dout <= r_last_tx ^ 8'h99;
         end
      end
      if ((w_spi_wr && w_spi_rd) || (!w_ram_csn && (w_spi_wr || w_spi_rd)))
         n_overlap <= n_overlap + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
      @(posedge r_ck); #1;
      r_hwe = 1'b1; r_haddr = a; r_hdata = d;
      @(posedge r_ck); #1;
      r_hwe = 1'b0;
   endtask

   task automatic start_job(input logic [7:0] a, input logic [31:0] tx, input logic [7:0] ctrl);
      host_wr(4'h0, a);
      host_wr(4'h4, tx[7:0]);
      host_wr(4'h5, tx[15:8]);
      host_wr(4'h6, tx[23:16]);
      host_wr(4'h7, tx[31:24]);
      host_wr(4'h2, ctrl);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (!mem[2][7] && k < budget) begin
         @(negedge r_ck);
         k++;
      end
      check(tag, {31'b0, mem[2][7]}, 32'd1);
      repeat (2) @(negedge r_ck);
   endtask

   function automatic logic [11:0] log_at(input int idx);
      if (idx < wlog.size()) return wlog[idx];
      return 12'hFFF;
   endfunction

   function automatic logic [31:0] out_vec();
      return {2'b00, w_ram_csn, w_ram_rw, w_ram_addr, w_ram_wdata, w_spi_wr, w_spi_rd,
              w_spi_adr, w_spi_din, w_busy, w_err};
   endfunction

   initial begin
      int s_log, s_wr, s_rd, s_polls, k;
      logic [7:0] rx_exp [4];
      rx_exp[0] = 8'h88; rx_exp[1] = 8'hBB; rx_exp[2] = 8'hAA; rx_exp[3] = 8'hDD;

      for (int i = 0; i < 16; i++) host_wr(4'(i), 8'h00);
      #1;
      check("reset_outputs", out_vec(), 32'h3000_0000);

      // Idle with GO=0: one control read every POLL_GAP+2 cycles, no SPI traffic.
      @(negedge r_ck); r_rstn = 1'b1;
      repeat (60) @(negedge r_ck);
      check("idle_read_period", rd_gap, 10);
      check("idle_spi_strobes", n_spiwr + n_spird, 0);
      check("idle_busy", {31'b0, w_busy}, 0);

      // Single byte, spi_master busy for two polls.
      poll_need = 3;
      host_wr(4'h8, 8'h00);
      s_log = wlog.size(); s_wr = n_spiwr; s_polls = n_polls;
      start_job(8'h10, 32'h0000_00A5, 8'h01);
      wait_done("job1_done", 500);
      check("job1_spi_writes", n_spiwr - s_wr, 3);
      check("job1_wr_addr", {20'b0, log_at(s_log)}, 32'h210);
      check("job1_wr_tx", {20'b0, log_at(s_log + 1)}, 32'h1A5);
      check("job1_wr_go", {20'b0, log_at(s_log + 2)}, 32'h001);
      check("job1_polls", n_polls - s_polls, 3);
      check("job1_rx", {24'b0, mem[8]}, 32'h3C);
      check("job1_ctrl", {24'b0, mem[2]}, 32'h80);
      check("job1_latency", ctrl_wr_cyc - last_ctrl_rd + 1, 19);
      check("job1_err", {31'b0, w_err}, 0);
      check("job1_busy", {31'b0, w_busy}, 0);

      // Four-byte burst, immediate completion.
      poll_need = 1;
      s_log = wlog.size(); s_wr = n_spiwr;
      start_job(8'h20, 32'h4433_2211, 8'h07);
      wait_done("job4_done", 800);
      check("job4_spi_writes", n_spiwr - s_wr, 12);
      for (int i = 0; i < 4; i++) begin
         check("job4_addr_seq", {20'b0, log_at(s_log + 3 * i)}, 32'h220 + 32'(i));
         check("job4_rx", {24'b0, mem[8 + i]}, {24'b0, rx_exp[i]});
      end
      check("job4_tx_byte3", {20'b0, log_at(s_log + 10)}, 32'h144);
      check("job4_ctrl", {24'b0, mem[2]}, 32'h86);
      check("job4_latency", ctrl_wr_cyc - last_ctrl_rd + 1, 45);

      // SPI address wraps past 8'hFF.
      s_log = wlog.size();
      start_job(8'hFE, 32'h0303_0303, 8'h05);
      wait_done("wrap_done", 800);
      check("wrap_addr0", {20'b0, log_at(s_log)}, 32'h2FE);
      check("wrap_addr1", {20'b0, log_at(s_log + 3)}, 32'h2FF);
      check("wrap_addr2", {20'b0, log_at(s_log + 6)}, 32'h200);
      check("wrap_ctrl", {24'b0, mem[2]}, 32'h84);

      // spi_master never finishes: timeout on byte 0.
      poll_need = 100000;
      host_wr(4'h8, 8'h77);
      s_wr = n_spiwr; s_rd = n_spird; s_polls = n_polls;
      start_job(8'h30, 32'h0000_0055, 8'h03);
      wait_done("tmo_done", 3000);
      check("tmo_polls", n_polls - s_polls, 1024);
      check("tmo_spi_reads", n_spird - s_rd, 1024);
      check("tmo_spi_writes", n_spiwr - s_wr, 3);
      check("tmo_no_rx_write", {24'b0, mem[8]}, 32'h77);
      check("tmo_ctrl", {24'b0, mem[2]}, 32'hC2);
      check("tmo_err", {31'b0, w_err}, 1);
      check("tmo_busy", {31'b0, w_busy}, 0);

      // Illegal length (LEN=6).
      poll_need = 1;
      s_wr = n_spiwr; s_rd = n_spird;
      host_wr(4'h2, 8'h0B);
      wait_done("bad_len_done", 200);
      check("bad_len_spi", (n_spiwr - s_wr) + (n_spird - s_rd), 0);
      check("bad_len_ctrl", {24'b0, mem[2]}, 32'hCA);
      check("bad_len_err", {31'b0, w_err}, 1);

      // Reset in the middle of a burst.
      poll_need = 100000;
      host_wr(4'h2, 8'h01);
      k = 0;
      while (!w_spi_rd && k < 300) begin
         @(posedge r_ck); #1;
         k++;
      end
      check("mid_poll_reached", {31'b0, w_spi_rd}, 1);
      check("mid_busy", {31'b0, w_busy}, 1);
      r_rstn = 1'b0;
      #1;
      check("mid_reset_outputs", out_vec(), 32'h3000_0000);
      repeat (4) @(negedge r_ck);
      check("mid_reset_ctrl_kept", {24'b0, mem[2]}, 32'h01);
      check("bus_overlap", n_overlap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
